ep_g3x8_onchip_mem_arbiter: RTL and testbench

Two-master Avalon-MM arbiter that shares a single port (s1) of the 256-bit on-chip memory between two DMA engines, the descriptor fetcher (m0) and the data mover (m1). It has a registered command stage toward the memory. It tracks outstanding reads by master ID so each master receives only its own read data. It sits between the DMA engines and the memory's s1 port in the endpoint's Avalon-MM fabric.

---
 rtl/ep_g3x8_onchip_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ep_g3x8_onchip_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ep_g3x8_onchip_mem_arbiter.sv
// Two-master round-robin arbiter onto a single 256-bit on-chip memory port.
// Optional macro ONCHIP_ARB_RDATA_REG_EN adds a readdata output register.
module ep_g3x8_onchip_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 256,
    parameter int BE_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [BE_W-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic              req0;
    logic              req1;
    logic              grant0;
    logic              grant1;
    logic              last_grant;

    logic              cmd_valid;
    logic              cmd_write;
    logic              cmd_id;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;
    logic [BE_W-1:0]   cmd_byteenable;

    logic              tag_valid;
    logic              tag_id;
    logic              rdv0;
    logic              rdv1;
    logic [DATA_W-1:0] rdata;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant: a lone requester wins; on a tie the master that did not win last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0 && (!req1 || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end
    end

    assign m0_waitrequest = reset | (req0 & ~grant0);
    assign m1_waitrequest = reset | (req1 & ~grant1);

    // Remember the last winner for round-robin tie breaking.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    // Command register: captures the granted request; a write wins over a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid      <= 1'b0;
            cmd_write      <= 1'b0;
            cmd_id         <= 1'b0;
            cmd_address    <= '0;
            cmd_writedata  <= '0;
            cmd_byteenable <= '0;
        end else begin
            cmd_valid <= grant0 | grant1;
            if (grant0) begin
                cmd_write      <= m0_write;
                cmd_id         <= 1'b0;
                cmd_address    <= m0_address;
                cmd_writedata  <= m0_writedata;
                cmd_byteenable <= m0_byteenable;
            end else if (grant1) begin
                cmd_write      <= m1_write;
                cmd_id         <= 1'b1;
                cmd_address    <= m1_address;
                cmd_writedata  <= m1_writedata;
                cmd_byteenable <= m1_byteenable;
            end
        end
    end

    // A command still in the register during reset must not reach the memory.
    assign mem_chipselect = cmd_valid & ~reset;
    assign mem_write      = cmd_valid & cmd_write & ~reset;
    assign mem_clken      = ~reset;
    assign mem_address    = cmd_address;
    assign mem_writedata  = cmd_writedata;
    assign mem_byteenable = cmd_byteenable;

    // Tag stage: follows a read issued to memory until its data comes back.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= 1'b0;
            tag_id    <= 1'b0;
        end else begin
            tag_valid <= cmd_valid & ~cmd_write;
            tag_id    <= cmd_id;
        end
    end

`ifdef ONCHIP_ARB_RDATA_REG_EN
    logic              rdv0_q;
    logic              rdv1_q;
    logic [DATA_W-1:0] rdata_q;

    // Extra output stage on the memory data and the routed valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdv0_q  <= 1'b0;
            rdv1_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            rdv0_q  <= tag_valid & ~tag_id;
            rdv1_q  <= tag_valid & tag_id;
            rdata_q <= mem_readdata;
        end
    end

    assign rdv0  = rdv0_q;
    assign rdv1  = rdv1_q;
    assign rdata = rdata_q;
`else
    assign rdv0  = tag_valid & ~tag_id;
    assign rdv1  = tag_valid & tag_id;
    assign rdata = mem_readdata;
`endif

    assign m0_readdatavalid = rdv0 & ~reset;
    assign m1_readdatavalid = rdv1 & ~reset;
    assign m0_readdata      = rdata;
    assign m1_readdata      = rdata;

endmodule

// File: tb/tb_ep_g3x8_onchip_mem_arbiter.sv
// Randomized bench for ep_g3x8_onchip_mem_arbiter with a transaction-level model.
// Honours ONCHIP_ARB_RDATA_REG_EN for the expected read latency.
module tb_ep_g3x8_onchip_mem_arbiter;

`ifdef ONCHIP_ARB_RDATA_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [9:0]   m0_address, m1_address;
    logic         m0_read, m1_read, m0_write, m1_write;
    logic [255:0] m0_writedata, m1_writedata;
    logic [31:0]  m0_byteenable, m1_byteenable;
    logic         m0_waitrequest, m1_waitrequest;
    logic [255:0] m0_readdata, m1_readdata;
    logic         m0_readdatavalid, m1_readdatavalid;
    logic [9:0]   mem_address;
    logic         mem_chipselect, mem_clken, mem_write;
    logic [255:0] mem_writedata;
    logic [31:0]  mem_byteenable;
    logic [255:0] mem_readdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ep_g3x8_onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_clken(mem_clken), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata)
    );

    // On-chip memory: registered read, byte-masked write.
    logic [255:0] ram [1024];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 32; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: expected memory image and expected read returns.
    typedef struct {
        int           cyc;
        bit           id;
        logic [255:0] d;
    } ev_t;

    ev_t          exp_q[$];
    logic [255:0] rmem [1024];
    bit           last_m = 1'b1;
    bit           pw_v = 1'b0;
    logic [9:0]   pw_a;
    logic [255:0] pw_d;
    logic [31:0]  pw_be;
    bit           pc_v = 1'b0;
    bit           pc_w = 1'b0;
    logic [9:0]   pc_a;
    bit           prev_rst = 1'b0;
    int           cyc = 0;
    int           rdv1_cnt = 0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]  = '0;
            rmem[i] = '0;
        end
        mem_readdata = '0;
    end

    always @(negedge clk) begin
        bit r0, r1, g0, g1, e0, e1, gw;
        logic [255:0] ed;
        logic [9:0] ga;
        logic [255:0] gd;
        logic [31:0] gbe;
        cyc++;
        if (m1_readdatavalid) rdv1_cnt++;
        if (reset) begin
            check("rst_wait0", {255'd0, m0_waitrequest}, 256'd1);
            check("rst_wait1", {255'd0, m1_waitrequest}, 256'd1);
            check("rst_rdv0", {255'd0, m0_readdatavalid}, 256'd0);
            check("rst_rdv1", {255'd0, m1_readdatavalid}, 256'd0);
            check("rst_cs", {255'd0, mem_chipselect}, 256'd0);
            check("rst_mw", {255'd0, mem_write}, 256'd0);
            check("rst_clken", {255'd0, mem_clken}, 256'd0);
            if (prev_rst) begin
                check("rst_addr", {246'd0, mem_address}, 256'd0);
                check("rst_wdata", mem_writedata, 256'd0);
                check("rst_be", {224'd0, mem_byteenable}, 256'd0);
            end
            exp_q.delete();
            pw_v = 1'b0;
            pc_v = 1'b0;
            last_m = 1'b1;
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (pw_v) begin
                for (int b = 0; b < 32; b++)
                    if (pw_be[b]) rmem[pw_a][b*8 +: 8] = pw_d[b*8 +: 8];
                pw_v = 1'b0;
            end
            check("clken", {255'd0, mem_clken}, 256'd1);
            check("cs", {255'd0, mem_chipselect}, {255'd0, pc_v});
            check("mwr", {255'd0, mem_write}, {255'd0, pc_v & pc_w});
            if (pc_v) check("maddr", {246'd0, mem_address}, {246'd0, pc_a});
            e0 = 1'b0;
            e1 = 1'b0;
            ed = '0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e0 = (exp_q[0].id == 1'b0);
                e1 = (exp_q[0].id == 1'b1);
                ed = exp_q[0].d;
                void'(exp_q.pop_front());
            end
            check("rdv0", {255'd0, m0_readdatavalid}, {255'd0, e0});
            check("rdv1", {255'd0, m1_readdatavalid}, {255'd0, e1});
            if (e0) check("rdata0", m0_readdata, ed);
            if (e1) check("rdata1", m1_readdata, ed);
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            g0 = r0 && (!r1 || last_m);
            g1 = r1 && !g0;
            check("wait0", {255'd0, m0_waitrequest}, {255'd0, r0 & ~g0});
            check("wait1", {255'd0, m1_waitrequest}, {255'd0, r1 & ~g1});
            pc_v = g0 | g1;
            if (pc_v) begin
                last_m = g1;
                gw  = g0 ? m0_write : m1_write;
                ga  = g0 ? m0_address : m1_address;
                gd  = g0 ? m0_writedata : m1_writedata;
                gbe = g0 ? m0_byteenable : m1_byteenable;
                pc_w = gw;
                pc_a = ga;
                if (gw) begin
                    pw_v = 1'b1;
                    pw_a = ga;
                    pw_d = gd;
                    pw_be = gbe;
                end else begin
                    exp_q.push_back('{cyc + LAT, g1, rmem[ga]});
                end
            end
        end
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set0(input bit rd, input bit wr, input logic [9:0] a,
                        input logic [255:0] d, input logic [31:0] be);
        m0_read = rd; m0_write = wr; m0_address = a;
        m0_writedata = d; m0_byteenable = be;
    endtask

    task automatic set1(input bit rd, input bit wr, input logic [9:0] a,
                        input logic [255:0] d, input logic [31:0] be);
        m1_read = rd; m1_write = wr; m1_address = a;
        m1_writedata = d; m1_byteenable = be;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set0(0, 0, '0, '0, '0);
        set1(0, 0, '0, '0, '0);
    endtask

    initial begin
        int c1;
        bit acc0, acc1;
        int k;
        reset = 1'b1;
        idle();
        step(3);
        reset = 1'b0;
        step(1);

        // Single write then read on m0
        set0(0, 1, 10'h005, {32{8'hA5}}, '1);
        step(1);
        idle();
        step(1);
        set0(1, 0, 10'h005, '0, '0);
        step(1);
        idle();
        step(5);

        // Contention on reads to two pre-written addresses
        set0(0, 1, 10'h001, rnd256(), '1);
        set1(0, 1, 10'h002, rnd256(), '1);
        step(2);
        idle();
        step(1);
        set0(1, 0, 10'h001, '0, '0);
        set1(1, 0, 10'h002, '0, '0);
        step(4);
        idle();
        step(5);

        // Partial byteenable write
        set0(0, 1, 10'h3FF, '1, 32'h0000_000F);
        step(1);
        set0(1, 0, 10'h3FF, '0, '0);
        step(1);
        idle();
        step(5);

        // Read and write together on m1 acts as a write
        c1 = rdv1_cnt;
        set1(1, 1, 10'h010, 256'h1234, '1);
        step(1);
        idle();
        step(5);
        check("rw_no_rdv1", 256'(rdv1_cnt - c1), 256'd0);
        set1(1, 0, 10'h010, '0, '0);
        step(1);
        idle();
        step(5);

        // Reset one cycle after an m1 read
        c1 = rdv1_cnt;
        set1(1, 0, 10'h010, '0, '0);
        step(1);
        idle();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(5);
        check("rst_drop_rdv1", 256'(rdv1_cnt - c1), 256'd0);
        set0(1, 0, 10'h005, '0, '0);
        set1(1, 0, 10'h002, '0, '0);
        #2;
        check("tie_after_rst", {254'd0, m1_waitrequest, m0_waitrequest}, 256'd2);
        step(2);
        idle();
        step(5);

        // Random traffic with held requests and rare resets
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc0 = (m0_read | m0_write) & ~m0_waitrequest;
            acc1 = (m1_read | m1_write) & ~m1_waitrequest;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 99) == 0);
            if (acc0 || !(m0_read | m0_write)) begin
                k = $urandom_range(0, 19);
                set0(k >= 6 && k < 13 || k == 19, k >= 13,
                     10'($urandom_range(0, 15)), rnd256(), $urandom);
            end
            if (acc1 || !(m1_read | m1_write)) begin
                k = $urandom_range(0, 19);
                set1(k >= 6 && k < 13 || k == 19, k >= 13,
                     10'($urandom_range(0, 15)), rnd256(), $urandom);
            end
        end
        #1;
        reset = 1'b0;
        idle();
        step(8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
